sdx_kernel_addwm_wm_dispatch: RTL and testbench
===============================================

// Module: sdx_kernel_addwm_wm_dispatch
// PURPOSE
//  Next-gen watermark path. Sits between the AXI read master's AXI4-Stream output and C_NUM_CH kernel compute lanes.
//  Splits one watermark stream into N lanes, selected per job: round-robin per packet (ROUND_ROBIN) or broadcast (BCAST).
//  Counts packets and signals job completion once the last packet has drained on every lane.
// PARAMETERS
//  C_DATA_WIDTH     512  stream tdata width (bits)
//  C_NUM_CH         4    output lanes, 1..16
//  C_PKT_CNT_WIDTH  32   width of packet-count control and counters
// PORTS
//  aclk            in   1                     single clock
//  areset_n        in   1                     async assert, active-low; deassert is sync to aclk upstream
//  ctrl_start      in   1                     1-cycle pulse; latches mode/mask/num_pkts
//  ctrl_mode       in   1                     0=ROUND_ROBIN, 1=BCAST
//  ctrl_ch_mask    in   C_NUM_CH              lanes enabled for this job
//  ctrl_num_pkts   in   C_PKT_CNT_WIDTH       packets (tlast-terminated) in this job
//  ctrl_done       out  1                     1-cycle pulse at job end
//  s_axis_tvalid   in   1                     input stream valid
//  s_axis_tready   out  1                     input stream ready
//  s_axis_tdata    in   C_DATA_WIDTH          input stream data
//  s_axis_tlast    in   1                     input stream last
//  m_axis_tvalid   out  C_NUM_CH              per-lane valid
//  m_axis_tready   in   C_NUM_CH              per-lane ready
//  m_axis_tdata    out  C_NUM_CH*C_DATA_WIDTH lane i in bits [i*DW +: DW]
//  m_axis_tlast    out  C_NUM_CH              per-lane last
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; beat slot empty; counters 0.
//  FSM: IDLE -> ROUTE on ctrl_start. Latch mode, mask and num_pkts.
//   If mask==0 or num_pkts==0: go IDLE->DONE directly and consume nothing.
//   ROUTE -> DRAIN when the tlast beat of packet num_pkts is accepted on s_axis.
//   DRAIN -> DONE when the beat slot is empty.
//   DONE: ctrl_done=1 for one cycle, then IDLE.
//   ctrl_start outside IDLE: ignored.
//  Beat slot: one registered beat holding data, last and a pending[C_NUM_CH] bitmap. Latency is 1 cycle s_axis->m_axis.
//  Load pending: BCAST = latched mask; ROUND_ROBIN = onehot(cur_ch).
//  m_axis_tvalid[i] = pending[i]. A lane handshake clears pending[i]. Valid/data stay stable until the handshake.
//  s_axis_tready = (state==ROUTE) && (slot empty || every pending bit is handshaking this cycle).
//   Gives full throughput; no combinational path from tvalid to tready.
//  BCAST: lanes accept independently; input stalls until the slowest enabled lane takes the beat.
//  ROUND_ROBIN: cur_ch starts at the lowest set mask bit.
//   Advance to the next set bit (cyclic, wraps C_NUM_CH-1 -> 0) only on the input tlast beat. Packets are never split.
//   A single enabled lane keeps cur_ch fixed.
//  pkt_cnt increments on the input tlast handshake and compares to the latched num_pkts. Counts wrap modulo 2^C_PKT_CNT_WIDTH.
//  Beats after the final packet stay unaccepted (tready=0) until the next job.
//  Async reset mid-job: the slot is dropped, all valids drop immediately, the FSM returns to IDLE, and no ctrl_done is issued.
// CONFIGURATION
//  `WM_DISPATCH_STATS_EN defined: adds output stat_beats[C_NUM_CH*C_PKT_CNT_WIDTH].
//   Holds per-lane accepted-beat counters; cleared on ctrl_start, hold after DONE, saturate at all-ones.
//  Undefined: port and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package sdx_kernel_addwm_wm_pkg: wm_mode_e {ROUND_ROBIN, BCAST}; wm_state_e {IDLE, ROUTE, DRAIN, DONE};
//   MAX_CH=16 constant.
//  Sub-module sdx_kernel_addwm_rr_next: combinational next-set-bit-after-cur_ch with wrap, from mask and cur_ch.
// TESTING
//  RR, N=4, mask=4'b1111, 8 pkts x 3 beats, all ready=1 -> lane order 0,1,2,3,0,1,2,3.
//   24 beats, no bubbles; ctrl_done 1 cycle after the last beat drains.
//  RR, mask=4'b1010, 3 pkts x 2 beats -> lanes 1,3,1 (wrap skips lanes 0/2); lanes 0/2 tvalid never 1.
//  BCAST, mask=4'b0111, lane 2 ready low 5 cycles per beat -> all lanes see identical data.
//   s_axis_tready low during the stall; lane 3 never valid.
//  num_pkts=0 or mask=0 -> ctrl_done 2 cycles after ctrl_start; s_axis_tready stays 0.
//  Reset mid-packet with a beat in the slot -> m_axis_tvalid=0 immediately.
//   New job after reset restarts at the lowest mask lane with no stale beat.
//  STATS_EN, BCAST mask=4'b0011, 10 beats -> stat_beats lane0=lane1=10, others 0; cleared by next ctrl_start.

Source files
------------

// File: rtl/sdx_kernel_addwm_wm_pkg.sv
// Shared types and helpers for the watermark dispatch block.
package sdx_kernel_addwm_wm_pkg;

    localparam int unsigned MAX_CH   = 16;
    localparam int unsigned CH_IDX_W = 4;

    typedef enum logic {
        ROUND_ROBIN = 1'b0,
        BCAST       = 1'b1
    } wm_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wm_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [CH_IDX_W-1:0] lowest_set(input logic [MAX_CH-1:0] mask);
        logic [CH_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) idx = CH_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdx_kernel_addwm_rr_next.sv
// Round-robin successor: next set mask bit after cur_ch, wrapping at C_NUM_CH-1.
// A mask with only cur_ch set returns cur_ch.
module sdx_kernel_addwm_rr_next
    import sdx_kernel_addwm_wm_pkg::*;
#(
    parameter int unsigned C_NUM_CH = 4
) (
    input  logic [C_NUM_CH-1:0] mask,
    input  logic [CH_IDX_W-1:0] cur_ch,
    output logic [CH_IDX_W-1:0] next_ch
);

    logic [MAX_CH-1:0]   mask_ext;
    logic [CH_IDX_W-1:0] idx;
    logic                found;

    assign mask_ext = MAX_CH'(mask);

    // Scan cur_ch+1 .. cur_ch+C_NUM_CH modulo C_NUM_CH, first hit wins.
    always_comb begin
        next_ch = cur_ch;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= C_NUM_CH; k++) begin
            idx = CH_IDX_W'((int'(cur_ch) + k) % C_NUM_CH);
            if (!found && mask_ext[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdx_kernel_addwm_wm_dispatch.sv
// Watermark dispatch: fans one AXI4-Stream out to C_NUM_CH lanes, round-robin per
// packet or broadcast, and pulses ctrl_done once the job's last packet has drained.
// Optional macro WM_DISPATCH_STATS_EN adds per-lane accepted-beat counters (stat_beats).
module sdx_kernel_addwm_wm_dispatch
    import sdx_kernel_addwm_wm_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH    = 512,
    parameter int unsigned C_NUM_CH        = 4,
    parameter int unsigned C_PKT_CNT_WIDTH = 32
) (
    input  logic                             aclk,
    input  logic                             areset_n,
    input  logic                             ctrl_start,
    input  logic                             ctrl_mode,
    input  logic [C_NUM_CH-1:0]              ctrl_ch_mask,
    input  logic [C_PKT_CNT_WIDTH-1:0]       ctrl_num_pkts,
    output logic                             ctrl_done,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                             s_axis_tlast,
    output logic [C_NUM_CH-1:0]              m_axis_tvalid,
    input  logic [C_NUM_CH-1:0]              m_axis_tready,
    output logic [C_NUM_CH*C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_NUM_CH-1:0]              m_axis_tlast
`ifdef WM_DISPATCH_STATS_EN
    ,
    output logic [C_NUM_CH*C_PKT_CNT_WIDTH-1:0] stat_beats
`endif
);

    wm_state_e                  state;
    wm_mode_e                   mode;
    logic [C_NUM_CH-1:0]        mask;
    logic [C_PKT_CNT_WIDTH-1:0] num_pkts;
    logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt;
    logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt_inc;
    logic [CH_IDX_W-1:0]        cur_ch;
    logic [CH_IDX_W-1:0]        rr_next_ch;

    // Beat slot: pending bit per lane still owed this beat.
    logic [C_NUM_CH-1:0]        pending;
    logic [C_DATA_WIDTH-1:0]    slot_data;
    logic                       slot_last;

    logic [C_NUM_CH-1:0]        lane_hs;
    logic [C_NUM_CH-1:0]        rr_onehot;
    logic [C_NUM_CH-1:0]        load_pend;
    logic                       slot_free;
    logic                       s_hs;
    logic                       last_hs;
    logic                       start_accept;

    sdx_kernel_addwm_rr_next #(
        .C_NUM_CH (C_NUM_CH)
    ) u_rr_next (
        .mask    (mask),
        .cur_ch  (cur_ch),
        .next_ch (rr_next_ch)
    );

    // slot_free: slot is empty after this edge (empty now, or every owed lane handshaking).
    assign lane_hs       = pending & m_axis_tready;
    assign slot_free     = (pending & ~m_axis_tready) == '0;
    assign s_axis_tready = (state == ROUTE) && slot_free;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign last_hs       = s_hs && s_axis_tlast;
    assign start_accept  = (state == IDLE) && ctrl_start;
    assign pkt_cnt_inc   = pkt_cnt + 1'b1;
    assign rr_onehot     = C_NUM_CH'(1) << cur_ch;
    assign load_pend     = (mode == BCAST) ? mask : rr_onehot;

    assign m_axis_tvalid = pending;
    assign m_axis_tlast  = pending & {C_NUM_CH{slot_last}};
    assign m_axis_tdata  = {C_NUM_CH{slot_data}};

    // Job control FSM with registered done pulse.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            mode      <= ROUND_ROBIN;
            mask      <= '0;
            num_pkts  <= '0;
            pkt_cnt   <= '0;
            cur_ch    <= '0;
            ctrl_done <= 1'b0;
        end else begin
            ctrl_done <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        mode     <= wm_mode_e'(ctrl_mode);
                        mask     <= ctrl_ch_mask;
                        num_pkts <= ctrl_num_pkts;
                        pkt_cnt  <= '0;
                        cur_ch   <= lowest_set(MAX_CH'(ctrl_ch_mask));
                        // Empty job: nothing to route, finish straight away.
                        if (ctrl_ch_mask == '0 || ctrl_num_pkts == '0) state <= DONE;
                        else                                           state <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (last_hs) begin
                        pkt_cnt <= pkt_cnt_inc;
                        if (mode == ROUND_ROBIN) cur_ch <= rr_next_ch;
                        if (pkt_cnt_inc == num_pkts) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (slot_free) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat slot: load on input handshake, otherwise retire lanes as they handshake.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pending   <= '0;
            slot_data <= '0;
            slot_last <= 1'b0;
        end else if (s_hs) begin
            pending   <= load_pend;
            slot_data <= s_axis_tdata;
            slot_last <= s_axis_tlast;
        end else begin
            pending <= pending & ~lane_hs;
        end
    end

`ifdef WM_DISPATCH_STATS_EN
    logic [C_PKT_CNT_WIDTH-1:0] beats [C_NUM_CH];

    // Per-lane accepted-beat counters, cleared by an accepted start, saturating.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < C_NUM_CH; i++) beats[i] <= '0;
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (start_accept) begin
                    beats[i] <= '0;
                end else if (lane_hs[i] && (beats[i] != '1)) begin
                    beats[i] <= beats[i] + 1'b1;
                end
            end
        end
    end

    // Flatten counters onto the stats bus.
    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            stat_beats[i*C_PKT_CNT_WIDTH +: C_PKT_CNT_WIDTH] = beats[i];
        end
    end
`endif

endmodule

// File: tb/tb_sdx_kernel_addwm_wm_dispatch.sv
// Directed bench for sdx_kernel_addwm_wm_dispatch (DW=32, 4 lanes, 16-bit counts).
// Define WM_DISPATCH_STATS_EN to also exercise the stat_beats counters.
module tb_sdx_kernel_addwm_wm_dispatch;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int PW = 16;

    logic            aclk;
    logic            areset_n;
    logic            ctrl_start;
    logic            ctrl_mode;
    logic [NC-1:0]   ctrl_ch_mask;
    logic [PW-1:0]   ctrl_num_pkts;
    logic            ctrl_done;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tlast;
    logic [NC-1:0]   m_axis_tvalid;
    logic [NC-1:0]   m_axis_tready;
    logic [NC*DW-1:0] m_axis_tdata;
    logic [NC-1:0]   m_axis_tlast;
`ifdef WM_DISPATCH_STATS_EN
    logic [NC*PW-1:0] stat_beats;
`endif

    logic [NC-1:0] ready_base;
    logic          stall_en;
    logic          stall2;
    int            stall_cnt;

    assign m_axis_tready = ready_base & ~(stall2 ? 4'b0100 : 4'b0000);

    sdx_kernel_addwm_wm_dispatch #(
        .C_DATA_WIDTH    (DW),
        .C_NUM_CH        (NC),
        .C_PKT_CNT_WIDTH (PW)
    ) dut (
        .aclk          (aclk),
        .areset_n      (areset_n),
        .ctrl_start    (ctrl_start),
        .ctrl_mode     (ctrl_mode),
        .ctrl_ch_mask  (ctrl_ch_mask),
        .ctrl_num_pkts (ctrl_num_pkts),
        .ctrl_done     (ctrl_done),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
`ifdef WM_DISPATCH_STATS_EN
        ,
        .stat_beats    (stat_beats)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int          lane;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t mon_q[$];
    int    valid_cnt [NC] = '{0, 0, 0, 0};
    int    done_cnt = 0;
    int    vectors = 0;
    int    miscompares = 0;
    int    stall_cycles;

    // Record every lane handshake, lane-valid cycles and done pulses.
    always @(posedge aclk) begin
        for (int i = 0; i < NC; i++) begin
            if (m_axis_tvalid[i]) valid_cnt[i] <= valid_cnt[i] + 1;
            if (m_axis_tvalid[i] && m_axis_tready[i])
                mon_q.push_back('{i, m_axis_tdata[i*DW +: DW], m_axis_tlast[i]});
        end
        if (ctrl_done) done_cnt <= done_cnt + 1;
    end

    // Lane 2 back-pressure: hold ready low 5 cycles for each beat it is offered.
    always @(negedge aclk) begin
        if (!stall_en) begin
            stall2    <= 1'b0;
            stall_cnt <= 0;
        end else if (m_axis_tvalid[2] && stall_cnt < 5) begin
            stall2    <= 1'b1;
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall2 <= 1'b0;
            if (m_axis_tvalid[2]) stall_cnt <= 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic md, input logic [NC-1:0] m, input logic [PW-1:0] n);
        ctrl_mode     = md;
        ctrl_ch_mask  = m;
        ctrl_num_pkts = n;
        ctrl_start    = 1'b1;
        @(negedge aclk);
        ctrl_start    = 1'b0;
    endtask

    // Present npk packets of bpp beats, data = base + beat index; counts stalled cycles.
    task automatic send(input int npk, input int bpp, input logic [31:0] base);
        int   b;
        int   guard;
        logic hs;
        b = 0;
        guard = 0;
        stall_cycles = 0;
        while (b < npk * bpp && guard < 2000) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 32'(b);
            s_axis_tlast  = ((b % bpp) == bpp - 1);
            #1;
            hs = s_axis_tready;
            @(negedge aclk);
            if (hs) b++;
            else    stall_cycles++;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("send_complete", 64'(b), 64'(npk * bpp));
    endtask

    task automatic wait_done(input string tag, output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < 50) begin
            @(negedge aclk);
            cycles++;
            if (ctrl_done) found = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(found), 64'd1);
        @(negedge aclk);
        check({tag, "_done_one_cycle"}, 64'(ctrl_done), 64'd0);
    endtask

    task automatic check_rr(input string tag, input int mark, input int npk, input int bpp,
                            input logic [31:0] base, input int lanes [8]);
        check({tag, "_count"}, 64'(mon_q.size() - mark), 64'(npk * bpp));
        for (int i = 0; i < npk * bpp && mark + i < mon_q.size(); i++) begin
            check({tag, "_lane"}, 64'(mon_q[mark+i].lane), 64'(lanes[i/bpp]));
            check({tag, "_data"}, 64'(mon_q[mark+i].data), 64'(base + 32'(i)));
            check({tag, "_last"}, 64'(mon_q[mark+i].last), 64'((i % bpp) == bpp - 1));
        end
    endtask

    initial begin
        int mark;
        int lat;
        int snap0;
        int snap2;
        int snap3;
        int dsnap;
        int lane_n [NC];
        int lanes_a [8];

        areset_n      = 1'b0;
        ctrl_start    = 1'b0;
        ctrl_mode     = 1'b0;
        ctrl_ch_mask  = '0;
        ctrl_num_pkts = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        ready_base    = 4'hf;
        stall_en      = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_done", 64'(ctrl_done), 64'd0);
        check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        areset_n = 1'b1;
        @(negedge aclk);

        // num_pkts == 0: done two cycles after start, nothing consumed
        mark = mon_q.size();
        s_axis_tvalid = 1'b1;
        start_job(1'b0, 4'hf, 16'd0);
        check("zpk_done_c1", 64'(ctrl_done), 64'd0);
        check("zpk_tready_c1", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        check("zpk_done_c2", 64'(ctrl_done), 64'd1);
        check("zpk_tready_c2", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        check("zpk_done_c3", 64'(ctrl_done), 64'd0);

        // mask == 0 behaves the same
        start_job(1'b0, 4'h0, 16'd5);
        check("zmask_done_c1", 64'(ctrl_done), 64'd0);
        check("zmask_tready_c1", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        check("zmask_done_c2", 64'(ctrl_done), 64'd1);
        @(negedge aclk);
        check("zmask_done_c3", 64'(ctrl_done), 64'd0);
        check("zero_jobs_no_beats", 64'(mon_q.size() - mark), 64'd0);
        s_axis_tvalid = 1'b0;

        // Round-robin over all 4 lanes, 8 packets x 3 beats
        lanes_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        mark = mon_q.size();
        start_job(1'b0, 4'hf, 16'd8);
        send(8, 3, 32'h100);
        check("rr4_no_bubbles", 64'(stall_cycles), 64'd0);
        check("rr4_drain_tready", 64'(s_axis_tready), 64'd0);
        wait_done("rr4", lat);
        check("rr4_done_latency", 64'(lat), 64'd2);
        check_rr("rr4", mark, 8, 3, 32'h100, lanes_a);

        // Round-robin on sparse mask 1010: lanes 1,3,1
        lanes_a = '{1, 3, 1, 0, 0, 0, 0, 0};
        mark  = mon_q.size();
        snap0 = valid_cnt[0];
        snap2 = valid_cnt[2];
        start_job(1'b0, 4'b1010, 16'd3);
        send(3, 2, 32'h180);
        wait_done("rr2", lat);
        check_rr("rr2", mark, 3, 2, 32'h180, lanes_a);
        check("rr2_lane0_never_valid", 64'(valid_cnt[0] - snap0), 64'd0);
        check("rr2_lane2_never_valid", 64'(valid_cnt[2] - snap2), 64'd0);

        // Broadcast to lanes 0..2 with lane 2 stalling 5 cycles per beat
        mark  = mon_q.size();
        snap3 = valid_cnt[3];
        stall_en = 1'b1;
        start_job(1'b1, 4'b0111, 16'd1);
        send(1, 3, 32'h300);
        check("bc_input_stall_cycles", 64'(stall_cycles), 64'd10);
        wait_done("bc", lat);
        stall_en = 1'b0;
        lane_n = '{0, 0, 0, 0};
        for (int i = mark; i < mon_q.size(); i++) begin
            check("bc_data", 64'(mon_q[i].data), 64'(32'h300 + 32'(lane_n[mon_q[i].lane])));
            check("bc_last", 64'(mon_q[i].last), 64'(lane_n[mon_q[i].lane] == 2));
            lane_n[mon_q[i].lane]++;
        end
        check("bc_lane0_beats", 64'(lane_n[0]), 64'd3);
        check("bc_lane1_beats", 64'(lane_n[1]), 64'd3);
        check("bc_lane2_beats", 64'(lane_n[2]), 64'd3);
        check("bc_lane3_beats", 64'(lane_n[3]), 64'd0);
        check("bc_lane3_never_valid", 64'(valid_cnt[3] - snap3), 64'd0);

        // Asynchronous reset with a beat held in the slot
        ready_base = 4'h0;
        start_job(1'b0, 4'b0110, 16'd2);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hdead_beef;
        s_axis_tlast  = 1'b0;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        check("mid_slot_valid", 64'(m_axis_tvalid), 64'b0010);
        check("mid_slot_data", 64'(m_axis_tdata[DW +: DW]), 64'h dead_beef);
        dsnap = done_cnt;
        #2;
        areset_n = 1'b0;
        #1;
        check("arst_tvalid_drop", 64'(m_axis_tvalid), 64'd0);
        check("arst_tlast_drop", 64'(m_axis_tlast), 64'd0);
        check("arst_tready", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        areset_n = 1'b1;
        repeat (2) @(negedge aclk);
        check("arst_no_done", 64'(done_cnt - dsnap), 64'd0);
        check("arst_idle_tvalid", 64'(m_axis_tvalid), 64'd0);

        // New job after reset starts at lowest mask lane, no stale beat
        ready_base = 4'hf;
        lanes_a = '{2, 0, 0, 0, 0, 0, 0, 0};
        mark = mon_q.size();
        start_job(1'b0, 4'b1100, 16'd1);
        send(1, 2, 32'h200);
        wait_done("post_rst", lat);
        check_rr("post_rst", mark, 1, 2, 32'h200, lanes_a);

`ifdef WM_DISPATCH_STATS_EN
        // Per-lane beat counters: broadcast 10 beats to lanes 0 and 1
        start_job(1'b1, 4'b0011, 16'd1);
        send(1, 10, 32'h400);
        wait_done("stats", lat);
        check("stats_after_job", 64'(stat_beats), {16'd0, 16'd0, 16'd10, 16'd10});
        start_job(1'b1, 4'b0011, 16'd0);
        check("stats_cleared_by_start", 64'(stat_beats), 64'd0);
        repeat (3) @(negedge aclk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
